// File: rtl/vector_alpha_extractor.sv
// -----------------------------------------------------------------------------
// vector_alpha_extractor
//   Computes the XNOR-net scaling factor alpha (mean absolute value) of a
//   block of BLOCK_VECS packed signed vectors, one lane per clock. It can also
//   produce the binarized sign map of the block.
//
//   Optional feature macro: VECTOR_ALPHA_SIGNS_EN
//     defined   -> sign_bits port and sign register exist
//     undefined -> no sign storage; all other behaviour identical
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort of the current block (highest priority)
//   in_valid   in   input vector valid
//   in_ready   out  block can accept a vector (registered)
//   in_vector  in   LANES*LANE_W packed vector, lane i = [i*LANE_W +: LANE_W]
//   out_valid  out  alpha/sign result valid (registered)
//   out_ready  in   consumer accepts the result
//   alpha      out  mean |x| of the block, zero-extended to LANE_W
//   sign_bits  out  bit v*LANES+i = (lane i of vector v >= 0) [macro only]
// -----------------------------------------------------------------------------
module vector_alpha_extractor #(
    parameter int unsigned LANE_W     = 32,
    parameter int unsigned LANES      = 8,
    parameter int unsigned BLOCK_VECS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   in_vector,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         alpha
`ifdef VECTOR_ALPHA_SIGNS_EN
    ,
    output logic [LANES*BLOCK_VECS-1:0] sign_bits
`endif
);

    localparam int unsigned ELEMS = LANES * BLOCK_VECS;
    localparam int unsigned SHIFT = $clog2(ELEMS);
    localparam int unsigned MAG_W = LANE_W - 1;
    localparam int unsigned ACC_W = MAG_W + SHIFT;
    localparam int unsigned VEC_BITS = LANES * LANE_W;
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VCNT_W = (BLOCK_VECS > 1) ? $clog2(BLOCK_VECS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LANE   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    lane_cnt_q;
    logic [VCNT_W-1:0]   vec_cnt_q;
    logic [VEC_BITS-1:0] vec_q;
    logic [ACC_W-1:0]    acc_q;

    logic [LANE_W-1:0]   lane_c;
    logic [MAG_W-1:0]    mag_c;
    logic [ACC_W-1:0]    acc_sum_c;
    logic                last_lane_c;
    logic                last_vec_c;

    // Holding register shifts right one lane per cycle, so the active lane is always at the bottom.
    assign lane_c      = vec_q[LANE_W-1:0];
    assign last_lane_c = (lane_cnt_q == CNT_W'(LANES - 1));
    assign last_vec_c  = (vec_cnt_q == VCNT_W'(BLOCK_VECS - 1));
    assign acc_sum_c   = acc_q + ACC_W'(mag_c);

    // Saturating absolute value: the most-negative code maps to the largest positive magnitude.
    always_comb begin
        mag_c = lane_c[MAG_W-1:0];
        if (lane_c[LANE_W-1]) begin
            if (lane_c[MAG_W-1:0] == '0) begin
                mag_c = '1;
            end else begin
                mag_c = MAG_W'((~lane_c) + LANE_W'(1));
            end
        end
    end

    // Next-state logic; clear overrides every handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = LANE;
                end
            end
            LANE: begin
                if (last_lane_c) begin
                    state_d = last_vec_c ? RESULT : IDLE;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // State register with registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == RESULT);
        end
    end

    // Datapath: vector capture, lane accumulation, block counters, alpha.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_q <= '0;
            vec_cnt_q  <= '0;
            vec_q      <= '0;
            acc_q      <= '0;
            alpha      <= '0;
        end else if (clear) begin
            lane_cnt_q <= '0;
            vec_cnt_q  <= '0;
            acc_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        vec_q      <= in_vector;
                        lane_cnt_q <= '0;
                    end
                end
                LANE: begin
                    acc_q      <= acc_sum_c;
                    vec_q      <= vec_q >> LANE_W;
                    lane_cnt_q <= lane_cnt_q + CNT_W'(1);
                    if (last_lane_c) begin
                        lane_cnt_q <= '0;
                        if (last_vec_c) begin
                            alpha <= LANE_W'(acc_sum_c >> SHIFT);
                        end else begin
                            vec_cnt_q <= vec_cnt_q + VCNT_W'(1);
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        acc_q     <= '0;
                        vec_cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VECTOR_ALPHA_SIGNS_EN
    logic [ELEMS-1:0] sign_acc_q;
    logic [ELEMS-1:0] sign_next_c;

    // Signs enter at the top and shift down; after ELEMS lanes, element k sits at bit k.
    always_comb begin
        sign_next_c = (sign_acc_q >> 1) | (ELEMS'(~lane_c[LANE_W-1]) << (ELEMS - 1));
    end

    // Sign collection during LANE; the visible map updates only when the block completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_acc_q <= '0;
            sign_bits  <= '0;
        end else if (clear) begin
            sign_acc_q <= '0;
        end else if (state_q == LANE) begin
            sign_acc_q <= sign_next_c;
            if (last_lane_c && last_vec_c) begin
                sign_bits <= sign_next_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vector_alpha_extractor.sv
// -----------------------------------------------------------------------------
// tb_vector_alpha_extractor
//   Directed and random blocks against a mean-|x| reference model; covers
//   latency, backpressure, clear in each state and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_vector_alpha_extractor;

    localparam int unsigned LANE_W     = 32;
    localparam int unsigned LANES      = 8;
    localparam int unsigned BLOCK_VECS = 4;
    localparam int unsigned VW         = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [VW-1:0]     in_vector;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] alpha;
`ifdef VECTOR_ALPHA_SIGNS_EN
    logic [LANES*BLOCK_VECS-1:0] sign_bits;
`endif

    int errors = 0;
    int checks = 0;

    logic [VW-1:0] blk [BLOCK_VECS];

    always #5 clk = ~clk;

    vector_alpha_extractor #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .BLOCK_VECS(BLOCK_VECS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vector(in_vector),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alpha    (alpha)
`ifdef VECTOR_ALPHA_SIGNS_EN
        ,
        .sign_bits(sign_bits)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: |x| with saturation of the most-negative code, then integer mean.
    function automatic longint lane_abs(input logic [LANE_W-1:0] x);
        longint v;
        longint lim;
        lim = (longint'(1) <<< (LANE_W - 1)) - 1;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > lim) v = lim;
        return v;
    endfunction

    function automatic logic [63:0] model_alpha(input logic [VW-1:0] b [BLOCK_VECS]);
        longint sum;
        logic [VW-1:0] vec;
        sum = 0;
        for (int v = 0; v < BLOCK_VECS; v++) begin
            vec = b[v];
            for (int i = 0; i < LANES; i++) sum += lane_abs(vec[i*LANE_W +: LANE_W]);
        end
        return 64'(sum / longint'(LANES * BLOCK_VECS));
    endfunction

    function automatic logic [63:0] model_signs(input logic [VW-1:0] b [BLOCK_VECS]);
        logic [63:0] s;
        logic [VW-1:0] vec;
        s = '0;
        for (int v = 0; v < BLOCK_VECS; v++) begin
            vec = b[v];
            for (int i = 0; i < LANES; i++)
                s[v*LANES + i] = ($signed(vec[i*LANE_W +: LANE_W]) >= 0);
        end
        return s;
    endfunction

    function automatic logic [VW-1:0] make_vec(input logic [LANE_W-1:0] val);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = val;
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] rand_lane();
        int unsigned r;
        r = $urandom_range(7, 0);
        case (r)
            0: return {1'b1, {(LANE_W-1){1'b0}}};
            1: return LANE_W'(0) - LANE_W'($urandom_range(20, 0));
            2: return LANE_W'($urandom_range(20, 0));
            default: return LANE_W'($urandom);
        endcase
    endfunction

    // Offer one vector, then measure edges until in_ready (or out_valid for the last vector).
    task automatic send_vec(input logic [VW-1:0] v, input bit last);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_wait_timeout", 64'(n < 50), 64'(1));
        in_vector = v;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("busy_after_accept", 64'(in_ready), 64'(0));
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(last ? out_valid : in_ready) && n < 50);
        check(last ? "result_latency" : "ready_latency", 64'(n), 64'(LANES));
    endtask

    // Full block from blk[], hold the result for 'hold' cycles, then consume it (or clear it).
    task automatic run_block(input int hold, input bit use_clear);
        logic [63:0] exp_a;
        exp_a = model_alpha(blk);
        for (int v = 0; v < BLOCK_VECS; v++) send_vec(blk[v], v == BLOCK_VECS - 1);
        check("alpha", 64'(alpha), exp_a);
`ifdef VECTOR_ALPHA_SIGNS_EN
        check("sign_bits", 64'(sign_bits), model_signs(blk));
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_alpha", 64'(alpha), exp_a);
            check("hold_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear     = use_clear;
        @(posedge clk); #1;
        out_ready = 1'b0;
        clear     = 1'b0;
        check("consumed_valid", 64'(out_valid), 64'(0));
        check("ready_after_consume", 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vector = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_alpha", 64'(alpha), 64'(0));
`ifdef VECTOR_ALPHA_SIGNS_EN
        check("rst_sign_bits", 64'(sign_bits), 64'(0));
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // All lanes 0x10
        for (int v = 0; v < BLOCK_VECS; v++) blk[v] = make_vec(32'h10);
        run_block(0, 1'b0);

        // Alternating -8 / +8, lane 0 negative
        for (int v = 0; v < BLOCK_VECS; v++)
            for (int i = 0; i < LANES; i++)
                blk[v][i*LANE_W +: LANE_W] = (i % 2 == 0) ? 32'hFFFF_FFF8 : 32'h0000_0008;
        run_block(1, 1'b0);

        // Most-negative code saturates
        for (int v = 0; v < BLOCK_VECS; v++) blk[v] = make_vec(32'h8000_0000);
        run_block(0, 1'b0);
        check("alpha_sat_const", 64'(alpha), 64'h7FFF_FFFF);

        // 1,2,3,4 -> sum 80, mean truncates to 2; also 5 cycles of backpressure
        for (int v = 0; v < BLOCK_VECS; v++) blk[v] = make_vec(LANE_W'(v + 1));
        run_block(5, 1'b0);
        check("alpha_trunc_const", 64'(alpha), 64'(2));

        // Random blocks with random backpressure
        for (int k = 0; k < 8; k++) begin
            for (int v = 0; v < BLOCK_VECS; v++)
                for (int i = 0; i < LANES; i++) blk[v][i*LANE_W +: LANE_W] = rand_lane();
            run_block(int'($urandom_range(3, 0)), 1'b0);
        end

        // Clear during lane 3 of the second vector of a block
        send_vec(make_vec(32'h7000_0000), 1'b0);
        in_vector = make_vec(32'h7000_0000);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_lane_ready", 64'(in_ready), 64'(1));
        check("clear_lane_valid", 64'(out_valid), 64'(0));
        for (int v = 0; v < BLOCK_VECS; v++) blk[v] = make_vec(32'h10);
        run_block(0, 1'b0);

        // Clear in IDLE drops a simultaneously offered vector
        in_vector = make_vec(32'h5);
        in_valid  = 1'b1;
        clear     = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        clear     = 1'b0;
        check("clear_idle_dropped", 64'(in_ready), 64'(1));

        // Clear together with out_ready in RESULT, then a fresh block
        for (int v = 0; v < BLOCK_VECS; v++) blk[v] = make_vec(LANE_W'(100 * (v + 1)));
        run_block(2, 1'b1);
        for (int v = 0; v < BLOCK_VECS; v++) blk[v] = make_vec(32'hFFFF_FFF0);
        run_block(0, 1'b0);

        // Asynchronous reset mid-LANE
        in_vector = make_vec(32'h3);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_alpha", 64'(alpha), 64'(0));
`ifdef VECTOR_ALPHA_SIGNS_EN
        check("async_rst_sign_bits", 64'(sign_bits), 64'(0));
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int v = 0; v < BLOCK_VECS; v++)
            for (int i = 0; i < LANES; i++) blk[v][i*LANE_W +: LANE_W] = rand_lane();
        run_block(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_alpha_extractor.md
# vector_alpha_extractor

Computes the XNOR-net scaling factor alpha (mean absolute value) and the binarized sign map of a block of packed signed vectors, one lane per cycle. It sits upstream of the scalar vector multiplier in the binarized-weight path. It consumes raw weight/activation vectors and produces the scalar that the multiplier later applies. This makes it the producer end of the scalar that feeds the multiplier.

## Interface
Parameters:
- LANE_W, 32: lane width; two's complement signed.
- LANES, 8: lanes per vector; power of two.
- BLOCK_VECS, 4: vectors per alpha block; power of two, ≥1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort of the current block.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_vector  in  LANES*LANE_W  packed vector; lane i = bits [i*LANE_W +: LANE_W].
- out_valid  out  1  alpha/sign result valid.
- out_ready  in  1  consumer accepts the result.
- alpha  out  LANE_W  mean absolute value of the block; non-negative.
- sign_bits  out  LANES*BLOCK_VECS  binarized signs; present only with VECTOR_ALPHA_SIGNS_EN.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - LANE: in_ready=0. An internal lane counter steps 0..LANES-1.
  - RESULT: out_valid=1.
- Transitions:
  - IDLE→LANE on in_valid&&in_ready. The vector is latched into a holding register at that edge; the lane counter is set to 0.
  - Within LANE, each edge adds |lane[cnt]| to the accumulator and increments cnt.
  - After lane LANES-1 is added: if vec_cnt==BLOCK_VECS-1, go to RESULT; else increment vec_cnt and go to IDLE.
  - RESULT→IDLE on out_ready. The accumulator and vec_cnt are zeroed at that edge.
- Absolute value: |x| for x=-2^(LANE_W-1) saturates to 2^(LANE_W-1)-1. No other saturation.
- Accumulator width: LANE_W-1+log2(LANES*BLOCK_VECS). It cannot overflow.
- alpha = accumulator >> log2(LANES*BLOCK_VECS). The shift truncates toward zero, and the result is zero-extended to LANE_W.
- alpha and sign_bits are registered. They are held stable for the whole time out_valid=1.
- clear has priority over every transition, including an input or output handshake in the same cycle. At the next edge it returns to IDLE and zeroes the accumulator, counters and out_valid. Any vector offered in that cycle is dropped.
- In RESULT, in_valid is ignored; in_ready=0.

## Timing
- Reset values: in_ready=1, out_valid=0, alpha=0, sign_bits=0, state IDLE, all counters and the accumulator 0.
- Reset is asynchronous and takes effect mid-operation; the partial block is discarded.
- Vector accepted at edge E:
  - Lanes are accumulated at edges E+1..E+LANES.
  - in_ready returns high after edge E+LANES, or out_valid rises then if this was the last vector of the block.
- Default configuration:
  - Block latency from the final accepting edge to out_valid is LANES edges (8).
  - Maximum throughput is one vector per LANES+1 cycles.
- Output handshake: the result is consumed on the edge where out_valid&&out_ready are both high. in_ready is high in the following cycle.

## Configuration
- VECTOR_ALPHA_SIGNS_EN defined:
  - sign_bits port and its register exist.
  - Bit index v*LANES+i is the sign of lane i of the v-th vector of the block.
  - The bit is 1 for x≥0 and 0 for x<0, written during LANE processing.
  - sign_bits updates only on entry to RESULT.
- Not defined: the port and its storage are absent; all other behaviour is identical.

## Test plan
- BLOCK_VECS=1, all lanes 0x00000010 → out_valid 8 edges after acceptance; alpha=0x00000010; sign_bits=0xFF.
- BLOCK_VECS=1, lanes alternating −8 (lane0) / +8 → alpha=0x00000008; sign_bits=0xAA.
- BLOCK_VECS=1, all lanes 0x80000000 → alpha=0x7FFFFFFF; sign_bits=0x00.
- BLOCK_VECS=4, vectors with all lanes 1, 2, 3, 4 respectively → sum 80; alpha=2 (truncated).
- Result backpressure: out_ready held low 5 cycles → alpha and out_valid stable and in_ready=0 throughout; in_ready=1 the cycle after out_ready is sampled high.
- Aborts:
  - clear pulsed during lane 3 → IDLE next cycle, then a fresh all-0x10 vector yields alpha=0x10.
  - rst_n pulsed low mid-LANE → all outputs at their reset values immediately.
